// File: rtl/wdt_pkg.sv
// Shared definitions for the Wishbone watchdog: register indices, CTRL/STATUS
// bit positions, FSM state encoding, bus write-strobe bundle and the default
// kick key.
package wdt_pkg;

  // Register indices decoded from wb_adr_i[4:2]
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_LOAD   = 3'd1;
  localparam logic [2:0] REG_COUNT  = 3'd2;
  localparam logic [2:0] REG_KICK   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  // CTRL bits
  localparam int CTRL_EN     = 0;
  localparam int CTRL_RST_EN = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bits (both write-one-to-clear)
  localparam int STAT_TIMEOUT  = 0;
  localparam int STAT_BAD_KICK = 1;

  localparam logic [31:0] WDT_KICK_KEY = 32'h5A5A_A5A5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WARN  = 2'd2,
    ST_RESET = 2'd3
  } wdt_state_e;

  // Accepted bus writes that the core cares about, one strobe each
  typedef struct packed {
    logic ctrl;    // CTRL written this edge
    logic kick;    // KICK written this edge
    logic w1c_to;  // STATUS written with the timeout bit set
  } wdt_wr_t;

  // Width of the reset-pulse down-counter (never zero)
  function automatic int pulse_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wdt_core.sv
// Watchdog core: down-counter, IDLE/RUN/WARN/RESET state machine and the
// reset-request pulse generator. Register storage (CTRL/LOAD/STATUS) lives in
// the bus wrapper; the core reports the events that modify it.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_wr           : accepted bus write strobes (CTRL, KICK, STATUS.timeout W1C)
//   i_wdat         : bus write data, low CNT_W bits
//   i_load         : current LOAD register
//   i_rst_en       : CTRL.rst_en
//   o_count        : COUNT register
//   o_state        : FSM state
//   o_to_set       : set STATUS.timeout this edge (first expiry)
//   o_kick_ok      : valid kick accepted this edge
//   o_kick_bad     : wrong kick value written while armed
//   o_en_clr       : clear CTRL.en (reset pulse finished)
//   o_wdt_rst      : registered reset request
module wdt_core
  import wdt_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] LOAD_DEFAULT = 32'h00FF_FFFF,
  parameter int          RST_PULSE    = 4,
  parameter logic [31:0] KICK_KEY     = WDT_KICK_KEY
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  wdt_wr_t          i_wr,
  input  logic [CNT_W-1:0] i_wdat,
  input  logic [CNT_W-1:0] i_load,
  input  logic             i_rst_en,
  output logic [CNT_W-1:0] o_count,
  output wdt_state_e       o_state,
  output logic             o_to_set,
  output logic             o_kick_ok,
  output logic             o_kick_bad,
  output logic             o_en_clr,
  output logic             o_wdt_rst
);

  localparam int               PW         = pulse_w(RST_PULSE);
  localparam logic [CNT_W-1:0] KEY        = KICK_KEY[CNT_W-1:0];
  localparam logic [PW-1:0]    PULSE_INIT = PW'(RST_PULSE - 1);

  wdt_state_e       r_state, w_state_nx;
  logic [CNT_W-1:0] r_count, w_count_nx;
  logic [PW-1:0]    r_pulse, w_pulse_nx;
  logic             r_rst,   w_rst_nx;

  logic w_armed, w_expire;

  assign w_armed    = (r_state == ST_RUN) || (r_state == ST_WARN);
  assign w_expire   = (r_count == '0);
  assign o_kick_ok  = i_wr.kick & w_armed & (i_wdat == KEY);
  assign o_kick_bad = i_wr.kick & w_armed & (i_wdat != KEY);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_count <= LOAD_DEFAULT[CNT_W-1:0];
      r_pulse <= '0;
      r_rst   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_pulse <= w_pulse_nx;
      r_rst   <= w_rst_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_pulse_nx = r_pulse;
    w_rst_nx   = r_rst;
    o_to_set   = 1'b0;
    o_en_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_wr.ctrl && i_wdat[CTRL_EN]) begin
          w_count_nx = i_load;
          w_state_nx = ST_RUN;
        end
      end
      ST_RUN, ST_WARN: begin
        if (i_wr.ctrl && !i_wdat[CTRL_EN]) begin
          // disable freezes COUNT where it is
          w_state_nx = ST_IDLE;
        end else if (o_kick_ok) begin
          // a valid kick beats an expiry on the same edge
          w_count_nx = i_load;
          w_state_nx = ST_RUN;
        end else if (w_expire) begin
          if (r_state == ST_RUN) begin
            w_count_nx = i_load;
            o_to_set   = 1'b1;
            w_state_nx = ST_WARN;
          end else if (i_rst_en) begin
            w_pulse_nx = PULSE_INIT;
            w_rst_nx   = 1'b1;
            w_state_nx = ST_RESET;
          end else begin
            w_count_nx = i_load;
          end
        end else begin
          w_count_nx = r_count - 1'b1;
          // acknowledging the warning re-arms the first stage
          if ((r_state == ST_WARN) && i_wr.w1c_to) w_state_nx = ST_RUN;
        end
      end
      ST_RESET: begin
        // pulse always runs to completion; only i_rst_n can cut it short
        if (r_pulse == '0) begin
          w_rst_nx   = 1'b0;
          o_en_clr   = 1'b1;
          w_state_nx = ST_IDLE;
        end else begin
          w_pulse_nx = r_pulse - 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign o_count   = r_count;
  assign o_state   = r_state;
  assign o_wdt_rst = r_rst;

endmodule

// File: rtl/wb_watchdog.sv
// Wishbone-slave watchdog timer. Holds the bus decode, CTRL/LOAD/STATUS
// registers, the registered read mux and the interrupt flop; counting and the
// reset pulse come from wdt_core.
//   clk_i, nrst_i        : system clock, async active-low reset
//   wb_cyc_i, wb_stb_i   : bus cycle / strobe
//   wb_we_i              : write enable
//   wb_adr_i[4:2]        : register index ([1:0] ignored)
//   wb_dat_i / wb_dat_o  : write data / registered read data (0 when no ack)
//   wb_ack_o             : single-cycle acknowledge
//   irq_o                : warning interrupt (level)
//   wdt_rst_o            : reset request pulse, RST_PULSE cycles
module wb_watchdog
  import wdt_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] LOAD_DEFAULT = 32'h00FF_FFFF,
  parameter int          RST_PULSE    = 4,
  parameter logic [31:0] KICK_KEY     = WDT_KICK_KEY
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o,
  output logic        wdt_rst_o
);

  logic             r_ack;
  logic [31:0]      r_dat;
  logic [2:0]       r_ctrl, w_ctrl_nx;
  logic [CNT_W-1:0] r_load;
  logic             r_to, w_to_nx;
  logic             r_bk, w_bk_nx;
  logic             r_irq;

  logic             w_req, w_wr;
  logic [2:0]       w_idx;
  logic             w_wr_ctrl, w_wr_load, w_wr_kick, w_wr_status;
  logic [31:0]      w_rdata;
  wdt_wr_t          w_wr_strb;

  logic [CNT_W-1:0] w_count;
  wdt_state_e       w_state;
  logic             w_to_set, w_kick_ok, w_kick_bad, w_en_clr, w_wdt_rst;

  // gating on r_ack forces an idle cycle between back-to-back accesses
  assign w_req       = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr        = w_req & wb_we_i;
  assign w_idx       = wb_adr_i[4:2];
  assign w_wr_ctrl   = w_wr & (w_idx == REG_CTRL);
  assign w_wr_load   = w_wr & (w_idx == REG_LOAD);
  assign w_wr_kick   = w_wr & (w_idx == REG_KICK);
  assign w_wr_status = w_wr & (w_idx == REG_STATUS);

  assign w_wr_strb.ctrl   = w_wr_ctrl;
  assign w_wr_strb.kick   = w_wr_kick;
  assign w_wr_strb.w1c_to = w_wr_status & wb_dat_i[STAT_TIMEOUT];

  wdt_core #(
    .CNT_W        (CNT_W),
    .LOAD_DEFAULT (LOAD_DEFAULT),
    .RST_PULSE    (RST_PULSE),
    .KICK_KEY     (KICK_KEY)
  ) u_core (
    .i_clk      (clk_i),
    .i_rst_n    (nrst_i),
    .i_wr       (w_wr_strb),
    .i_wdat     (wb_dat_i[CNT_W-1:0]),
    .i_load     (r_load),
    .i_rst_en   (r_ctrl[CTRL_RST_EN]),
    .o_count    (w_count),
    .o_state    (w_state),
    .o_to_set   (w_to_set),
    .o_kick_ok  (w_kick_ok),
    .o_kick_bad (w_kick_bad),
    .o_en_clr   (w_en_clr),
    .o_wdt_rst  (w_wdt_rst)
  );

  generate
    if (CNT_W < 32) begin : g_dat_hi
      logic w_unused_dat_hi;
      assign w_unused_dat_hi = ^wb_dat_i[31:CNT_W];
    end
  endgenerate

  logic w_unused_adr;
  assign w_unused_adr = ^wb_adr_i[1:0];

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_CTRL:   w_rdata[2:0]       = r_ctrl;
      REG_LOAD:   w_rdata[CNT_W-1:0] = r_load;
      REG_COUNT:  w_rdata[CNT_W-1:0] = w_count;
      REG_STATUS: begin
        w_rdata[STAT_TIMEOUT]  = r_to;
        w_rdata[STAT_BAD_KICK] = r_bk;
      end
      default: w_rdata = '0;
    endcase
  end

  always_comb begin
    w_ctrl_nx = r_ctrl;
    if (w_wr_ctrl) begin
      // en is locked while the reset pulse is running
      if (w_state == ST_RESET) w_ctrl_nx = {wb_dat_i[2:1], r_ctrl[CTRL_EN]};
      else                     w_ctrl_nx = wb_dat_i[2:0];
    end
    if (w_en_clr) w_ctrl_nx[CTRL_EN] = 1'b0;
  end

  // kick clears, expiry sets, W1C clears; set beats a same-edge W1C
  always_comb begin
    w_to_nx = r_to;
    if (w_kick_ok)                                 w_to_nx = 1'b0;
    else if (w_to_set)                             w_to_nx = 1'b1;
    else if (w_wr_status && wb_dat_i[STAT_TIMEOUT]) w_to_nx = 1'b0;
  end

  always_comb begin
    w_bk_nx = r_bk;
    if (w_kick_bad)                                  w_bk_nx = 1'b1;
    else if (w_wr_status && wb_dat_i[STAT_BAD_KICK]) w_bk_nx = 1'b0;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_ctrl <= '0;
      r_load <= LOAD_DEFAULT[CNT_W-1:0];
      r_to   <= 1'b0;
      r_bk   <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_ack  <= w_req;
      r_dat  <= (w_req && !wb_we_i) ? w_rdata : '0;
      r_ctrl <= w_ctrl_nx;
      if (w_wr_load) r_load <= wb_dat_i[CNT_W-1:0];
      r_to   <= w_to_nx;
      r_bk   <= w_bk_nx;
      r_irq  <= r_to & r_ctrl[CTRL_IRQ_EN];
    end
  end

  assign wb_ack_o  = r_ack;
  assign wb_dat_o  = r_dat;
  assign irq_o     = r_irq;
  assign wdt_rst_o = w_wdt_rst;

endmodule

// File: tb/tb_wb_watchdog.sv
// Bench for wb_watchdog: register table, hand-timed sequences for warning,
// reset pulse, kicks, same-edge races and mid-pulse reset, then randomized
// bus traffic checked cycle by cycle against a behavioural model.
module tb_wb_watchdog;

  localparam logic [31:0] KEY   = 32'h5A5A_A5A5;
  localparam logic [31:0] LDEF  = 32'h00FF_FFFF;
  localparam int          PULSE = 4;
  localparam int MI = 0, MR = 1, MW = 2, MX = 3;  // idle/run/warn/reset-pulse

  logic        clk_i = 1'b0;
  logic        nrst_i = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [4:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, irq_o, wdt_rst_o;

  int total = 0;
  int bad   = 0;

  wb_watchdog dut (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_ack_o  (wb_ack_o),
    .irq_o     (irq_o),
    .wdt_rst_o (wdt_rst_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL time_limit got=running want=finished");
    $fatal(1, "time limit");
  end

  // ---------------- behavioural model ----------------
  logic [2:0]  m_ctrl;
  logic [31:0] m_load, m_count, m_dat;
  bit          m_to, m_bk, m_rst, m_irq, m_ack;
  int          m_mode, m_pulse;

  task automatic model_reset();
    m_ctrl = '0; m_load = LDEF; m_count = LDEF; m_dat = '0;
    m_to = 0; m_bk = 0; m_rst = 0; m_irq = 0; m_ack = 0;
    m_mode = MI; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input bit we, input logic [2:0] idx,
                            input logic [31:0] dat);
    bit acc, wr, armed, kick_ok, kick_bad, w1c, set_to, en_clr;
    logic [31:0] rd;
    acc = v && !m_ack;
    wr  = acc && we;
    rd  = '0;
    if (acc && !we) begin
      case (idx)
        3'd0: rd = {29'd0, m_ctrl};
        3'd1: rd = m_load;
        3'd2: rd = m_count;
        3'd4: rd = {30'd0, m_bk, m_to};
        default: rd = '0;
      endcase
    end
    armed    = (m_mode == MR) || (m_mode == MW);
    kick_ok  = wr && idx == 3'd3 && dat == KEY && armed;
    kick_bad = wr && idx == 3'd3 && dat != KEY && armed;
    w1c      = wr && idx == 3'd4;
    set_to   = 0;
    en_clr   = 0;
    m_irq    = m_to && m_ctrl[2];
    if (m_mode == MI) begin
      if (wr && idx == 3'd0 && dat[0]) begin m_count = m_load; m_mode = MR; end
    end else if (m_mode == MX) begin
      if (m_pulse == 0) begin m_rst = 0; en_clr = 1; m_mode = MI; end
      else m_pulse--;
    end else begin
      if (wr && idx == 3'd0 && !dat[0]) m_mode = MI;
      else if (kick_ok) begin m_count = m_load; m_mode = MR; end
      else if (m_count == 0) begin
        if (m_mode == MR) begin m_count = m_load; set_to = 1; m_mode = MW; end
        else if (m_ctrl[1]) begin m_mode = MX; m_pulse = PULSE - 1; m_rst = 1; end
        else m_count = m_load;
      end else begin
        m_count = m_count - 1;
        if (m_mode == MW && w1c && dat[0]) m_mode = MR;
      end
    end
    if (wr && idx == 3'd0)
      m_ctrl = (m_mode == MX && !en_clr) || (m_rst && m_mode == MX) ? {dat[2:1], m_ctrl[0]} : dat[2:0];
    if (en_clr) m_ctrl[0] = 1'b0;
    if (wr && idx == 3'd1) m_load = dat;
    if (kick_ok)              m_to = 0;
    else if (set_to)          m_to = 1;
    else if (w1c && dat[0])   m_to = 0;
    if (kick_bad)             m_bk = 1;
    else if (w1c && dat[1])   m_bk = 0;
    m_ack = acc;
    m_dat = rd;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  int mode_before;  // model mode sampled before the current step

  task automatic tick(input bit v, input bit we, input logic [2:0] idx, input logic [31:0] dat);
    logic [1:0] lo;
    @(negedge clk_i);
    lo = 2'($urandom_range(0, 3));
    wb_cyc_i = v; wb_stb_i = v; wb_we_i = we;
    wb_adr_i = {idx, lo};
    wb_dat_i = dat;
    mode_before = m_mode;
    model_step(v, we, idx, dat);
    @(posedge clk_i);
    #1;
    chk("outputs", {29'd0, wdt_rst_o, irq_o, wb_ack_o, wb_dat_o},
                   {29'd0, m_rst, m_irq, m_ack, m_dat});
  endtask

  task automatic idle();
    tick(0, 0, 3'd0, 32'd0);
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] dat);
    tick(1, 1, idx, dat);
    idle();
  endtask

  task automatic do_reset();
    nrst_i = 1'b0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
    model_reset();
    repeat (2) @(negedge clk_i);
    chk("rst_outs", {wdt_rst_o, irq_o, wb_ack_o, wb_dat_o}, 35'd0);
    nrst_i = 1'b1;
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  idx;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[20];

  initial begin
    model_reset();
    tbl[0]  = '{0, 3'd0, 32'h0,        32'h0};
    tbl[1]  = '{0, 3'd1, 32'h0,        LDEF};
    tbl[2]  = '{0, 3'd2, 32'h0,        LDEF};
    tbl[3]  = '{0, 3'd4, 32'h0,        32'h0};
    tbl[4]  = '{0, 3'd5, 32'h0,        32'h0};
    tbl[5]  = '{1, 3'd1, 32'h1234,     32'h0};
    tbl[6]  = '{0, 3'd1, 32'h0,        32'h1234};
    tbl[7]  = '{0, 3'd2, 32'h0,        LDEF};
    tbl[8]  = '{1, 3'd0, 32'h6,        32'h0};
    tbl[9]  = '{0, 3'd0, 32'h0,        32'h6};
    tbl[10] = '{1, 3'd6, 32'hFFFF_FFFF, 32'h0};
    tbl[11] = '{0, 3'd6, 32'h0,        32'h0};
    tbl[12] = '{1, 3'd3, KEY,          32'h0};
    tbl[13] = '{0, 3'd4, 32'h0,        32'h0};
    tbl[14] = '{1, 3'd3, 32'h1,        32'h0};
    tbl[15] = '{0, 3'd4, 32'h0,        32'h0};
    tbl[16] = '{0, 3'd3, 32'h0,        32'h0};
    tbl[17] = '{1, 3'd2, 32'h55,       32'h0};
    tbl[18] = '{0, 3'd2, 32'h0,        LDEF};
    tbl[19] = '{1, 3'd0, 32'h0,        32'h0};

    // 1. reset values and register table
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(1, tbl[i].we, tbl[i].idx, tbl[i].dat);
      if (!tbl[i].we) chk($sformatf("tbl%0d", i), {32'd0, wb_dat_o}, {32'd0, tbl[i].exp});
      idle();
    end

    // 2. warning stage: irq one cycle after timeout, COUNT reloaded
    do_reset();
    wr(3'd1, 32'd10);
    tick(1, 1, 3'd0, 32'h5);
    for (int k = 1; k <= 11; k++) begin
      idle();
      chk("warn_irq_low", {62'd0, irq_o, wdt_rst_o}, 64'd0);
    end
    tick(1, 0, 3'd2, 32'd0);
    chk("warn_count", {32'd0, wb_dat_o}, 64'd10);
    chk("warn_irq", {63'd0, irq_o}, 64'd1);
    idle();
    tick(1, 0, 3'd4, 32'd0);
    chk("warn_status", {32'd0, wb_dat_o}, 64'd1);
    idle();

    // 3. reset request pulse timing
    do_reset();
    wr(3'd1, 32'd10);
    tick(1, 1, 3'd0, 32'h7);
    for (int k = 1; k <= 30; k++) begin
      idle();
      chk($sformatf("pulse_k%0d", k), {63'd0, wdt_rst_o}, {63'd0, (k >= 22 && k <= 25)});
    end
    tick(1, 0, 3'd0, 32'd0);
    chk("pulse_ctrl", {32'd0, wb_dat_o}, 64'd6);
    idle();

    // 4. periodic kicks keep it quiet; a bad key sets bad_kick only
    do_reset();
    wr(3'd1, 32'd20);
    tick(1, 1, 3'd0, 32'h7);
    for (int i = 1; i <= 200; i++) begin
      if (i % 15 == 0) tick(1, 1, 3'd3, KEY);
      else idle();
      if (i % 50 == 0) chk("kick_quiet", {62'd0, irq_o, wdt_rst_o}, 64'd0);
    end
    tick(1, 1, 3'd3, 32'h1234);
    idle();
    tick(1, 0, 3'd4, 32'd0);
    chk("badkick_status", {32'd0, wb_dat_o}, 64'd2);
    idle();
    tick(1, 0, 3'd2, 32'd0);
    chk("badkick_noreload", {32'd0, wb_dat_o}, 64'd11);
    idle();

    // 5. same-edge races
    do_reset();
    wr(3'd1, 32'd5);
    tick(1, 1, 3'd0, 32'h1);
    repeat (5) idle();
    tick(1, 1, 3'd3, KEY);           // lands on the expiry edge
    idle();
    tick(1, 0, 3'd4, 32'd0);
    chk("race_kick_to", {32'd0, wb_dat_o}, 64'd0);
    repeat (3) idle();
    tick(1, 1, 3'd4, 32'd1);         // W1C on the edge that sets timeout
    idle();
    tick(1, 0, 3'd4, 32'd0);
    chk("race_w1c_set", {32'd0, wb_dat_o}, 64'd1);
    idle();
    tick(1, 1, 3'd4, 32'd1);         // W1C in WARN re-arms RUN
    idle();
    tick(1, 0, 3'd4, 32'd0);
    chk("w1c_cleared", {32'd0, wb_dat_o}, 64'd0);
    idle();
    tick(1, 0, 3'd4, 32'd0);
    chk("rerun_expired", {32'd0, wb_dat_o}, 64'd1);
    idle();

    // 6. async reset during the second pulse cycle
    do_reset();
    wr(3'd1, 32'd2);
    tick(1, 1, 3'd0, 32'h3);
    repeat (6) idle();
    chk("mid_pulse_c1", {63'd0, wdt_rst_o}, 64'd1);
    idle();
    chk("mid_pulse_c2", {63'd0, wdt_rst_o}, 64'd1);
    #2 nrst_i = 1'b0;
    #1 chk("async_rst", {62'd0, wdt_rst_o, wb_ack_o}, 64'd0);
    do_reset();
    tick(1, 0, 3'd0, 32'd0); chk("post_ctrl",   {32'd0, wb_dat_o}, 64'd0);       idle();
    tick(1, 0, 3'd1, 32'd0); chk("post_load",   {32'd0, wb_dat_o}, {32'd0, LDEF}); idle();
    tick(1, 0, 3'd2, 32'd0); chk("post_count",  {32'd0, wb_dat_o}, {32'd0, LDEF}); idle();
    tick(1, 0, 3'd4, 32'd0); chk("post_status", {32'd0, wb_dat_o}, 64'd0);       idle();

    // 7. randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      int r;
      if (i % 600 == 599) do_reset();
      r = $urandom_range(0, 15);
      if (r <= 6) idle();
      else if (r == 7)  tick(1, 1, 3'd0, 32'($urandom_range(0, 7)) | 32'(($urandom_range(0, 3) != 0)));
      else if (r == 8)  tick(1, 1, 3'd1, 32'($urandom_range(0, 12)));
      else if (r <= 10) tick(1, 1, 3'd3, KEY);
      else if (r == 11) tick(1, 1, 3'd3, KEY ^ (32'd1 << $urandom_range(0, 31)));
      else if (r == 12) tick(1, 1, 3'd4, 32'($urandom_range(0, 3)));
      else              tick(1, 0, 3'($urandom_range(0, 7)), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
